cga_attrib_serializer: RTL and testbench

//   Text-mode pixel stage directly upstream of the IRGB-to-RGB palette port.
//   - Latches the font-ROM row byte and attribute byte of each character cell.
//   - Shifts out one pixel per pixel-enable and applies attribute colours, blink, cursor and border.
//   - Produces the registered 4-bit IRGB index that drives the palette port's video input.

---
 rtl/cga_attrib_serializer.sv | 99 +++++++++
 tb/tb_cga_attrib_serializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cga_attrib_serializer.sv
// CGA text-mode attribute serializer: glyph shift, colour, blink, cursor, border.
// Optional cursor overlay is built only when CGA_CURSOR_EN is defined.
module cga_attrib_serializer #(
   parameter int BLINK_BITS = 5,
   parameter int CURSOR_BIT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       char_load,
   input  logic [7:0] font_row,
   input  logic [7:0] attr,
   input  logic       display_en,
   input  logic       cursor_active,
   input  logic       vsync,
   input  logic       blink_mode,
   input  logic [3:0] border_color,
   output logic [3:0] video
);

   logic [7:0]            shift_q, shift_d;
   logic [7:0]            attr_q, attr_d;
   logic [3:0]            video_q, video_d;
   logic [BLINK_BITS-1:0] frame_q, frame_d;
   logic                  vsync_q;
   logic                  on;
   logic [3:0]            fg, bg, pix;

`ifdef CGA_CURSOR_EN
   logic cursor_q, cursor_d;
`else
   logic cursor_unused;
   assign cursor_unused = cursor_active;
`endif

   always_comb begin
      fg = attr_q[3:0];
      bg = blink_mode ? {1'b0, attr_q[6:4]} : attr_q[7:4];
      on = shift_q[7];
      if (blink_mode && attr_q[7] && !frame_q[BLINK_BITS-1])
         on = 1'b0;
`ifdef CGA_CURSOR_EN
      // Cursor wins over character blink during its visible phase
      if (cursor_q && frame_q[CURSOR_BIT])
         on = 1'b1;
`endif
      pix = on ? fg : bg;
   end

   always_comb begin
      shift_d = shift_q;
      attr_d  = attr_q;
      video_d = video_q;
      frame_d = frame_q;
`ifdef CGA_CURSOR_EN
      cursor_d = cursor_q;
`endif
      if (pix_en) begin
         video_d = display_en ? pix : border_color;
         if (char_load) begin
            shift_d = font_row;
            attr_d  = attr;
`ifdef CGA_CURSOR_EN
            cursor_d = cursor_active;
`endif
         end else begin
            shift_d = {shift_q[6:0], 1'b0};
         end
      end
      if (vsync && !vsync_q)
         frame_d = frame_q + BLINK_BITS'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= 8'h00;
         attr_q  <= 8'h00;
         video_q <= 4'h0;
         frame_q <= '0;
         vsync_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         attr_q  <= attr_d;
         video_q <= video_d;
         frame_q <= frame_d;
         vsync_q <= vsync;
      end
   end

`ifdef CGA_CURSOR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cursor_q <= 1'b0;
      else       cursor_q <= cursor_d;
   end
`endif

   assign video = video_q;

endmodule

// File: tb/tb_cga_attrib_serializer.sv
// Bench for cga_attrib_serializer: vector table, corner sequences, random vs model.
module tb_cga_attrib_serializer;

   logic       clk = 1'b0;
   logic       reset, pix_en, char_load, display_en, cursor_active;
   logic       vsync, blink_mode;
   logic [7:0] font_row, attr;
   logic [3:0] border_color, video;

   int errors = 0;
   int checks = 0;

   // reference model: cell contents plus pixel index within the cell
   int   m_font, m_attr, m_k, m_frame;
   bit   m_cur, m_vs;
   logic [3:0] m_video;

   typedef struct {
      logic [7:0]  font;
      logic [7:0]  at;
      bit          bm;
      bit          de;
      logic [3:0]  bc;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[5];

   always #5 clk = ~clk;

   cga_attrib_serializer dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .char_load(char_load),
      .font_row(font_row), .attr(attr), .display_en(display_en),
      .cursor_active(cursor_active), .vsync(vsync), .blink_mode(blink_mode),
      .border_color(border_color), .video(video)
   );

   task automatic model_reset();
      m_font = 0; m_attr = 0; m_k = 0; m_frame = 0;
      m_cur = 0; m_vs = 0; m_video = 4'h0;
   endtask

   function automatic logic [3:0] model_pix(bit bm);
      int fg, bg;
      bit on;
      fg = m_attr % 16;
      bg = bm ? (m_attr / 16) % 8 : m_attr / 16;
      on = (m_k < 8) ? bit'((m_font >> (7 - m_k)) & 1) : 1'b0;
      if (bm && m_attr >= 128 && m_frame < 16) on = 1'b0;
`ifdef CGA_CURSOR_EN
      if (m_cur && ((m_frame / 8) % 2) == 1) on = 1'b1;
`endif
      return on ? 4'(fg) : 4'(bg);
   endfunction

   task automatic chk(input string nm, input logic [3:0] exp);
      checks++;
      if (video !== exp) begin
         errors++;
         $display("FAIL %s: video=%h expected=%h", nm, video, exp);
      end
   endtask

   task automatic cyc(input bit pe, input bit ld, input logic [7:0] fr,
                      input logic [7:0] at, input bit de, input bit ca,
                      input bit vs, input bit bm, input logic [3:0] bc,
                      input string nm);
      logic [3:0] nv;
      pix_en = pe; char_load = ld; font_row = fr; attr = at;
      display_en = de; cursor_active = ca; vsync = vs;
      blink_mode = bm; border_color = bc;
      nv = de ? model_pix(bm) : bc;
      @(posedge clk);
      #1;
      if (pe) begin
         m_video = nv;
         if (ld) begin
            m_font = int'(fr); m_attr = int'(at); m_cur = ca; m_k = 0;
         end else if (m_k < 8) begin
            m_k++;
         end
      end
      if (vs && !m_vs) m_frame = (m_frame + 1) % 32;
      m_vs = vs;
      chk(nm, m_video);
   endtask

   task automatic vpulses(input int n, input bit bm);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 8'h00, 8'h00, 1, 0, 1, bm, 4'h0, "vs_hi");
         cyc(0, 0, 8'h00, 8'h00, 1, 0, 0, bm, 4'h0, "vs_lo");
      end
   endtask

   initial begin
      logic [3:0] cur_exp;
      tbl[0] = '{8'hA5, 8'h1E, 1'b0, 1'b1, 4'h0, 32'hE1E11E1E};
      tbl[1] = '{8'h00, 8'hC2, 1'b0, 1'b1, 4'h0, 32'hCCCCCCCC};
      tbl[2] = '{8'hFF, 8'h9F, 1'b1, 1'b1, 4'h0, 32'h11111111};
      tbl[3] = '{8'hA5, 8'h1E, 1'b0, 1'b0, 4'h6, 32'h66666666};
      tbl[4] = '{8'h3C, 8'h4A, 1'b1, 1'b1, 4'h0, 32'h44AAAA44};

      reset = 1'b1; pix_en = 0; char_load = 0; font_row = 0; attr = 0;
      display_en = 0; cursor_active = 0; vsync = 0; blink_mode = 0;
      border_color = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_video", 4'h0);
      reset = 1'b0;

      for (int r = 0; r < 5; r++) begin
         cyc(1, 1, tbl[r].font, tbl[r].at, tbl[r].de, 0, 0, tbl[r].bm,
             tbl[r].bc, "load");
         for (int p = 0; p < 8; p++) begin
            cyc(1, 0, 8'h00, 8'h00, tbl[r].de, 0, 0, tbl[r].bm,
                tbl[r].bc, "model");
            chk($sformatf("table%0d_px%0d", r, p), tbl[r].exp[31-4*p -: 4]);
         end
      end

      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 4'h0, "overshift");
      chk("overshift_bg", 4'h4);
      cyc(1, 1, 8'hFF, 8'h0F, 0, 0, 0, 0, 4'h6, "border_ld");
      cyc(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h6, "border");
      chk("border", 4'h6);
      cyc(0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 4'h9, "hold");
      chk("hold", 4'h6);

      // blink phase: off for frames 0..15, on for 16..31, off after wrap
      cyc(1, 1, 8'hFF, 8'h9F, 1, 0, 0, 1, 4'h0, "blink_ld");
      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 4'h0, "blink0");
      chk("blink_f0", 4'h1);
      vpulses(16, 1);
      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 4'h0, "blink16");
      chk("blink_f16", 4'hF);
      vpulses(16, 1);
      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 4'h0, "blink32");
      chk("blink_wrap", 4'h1);

      cyc(1, 1, 8'h00, 8'h07, 1, 1, 0, 0, 4'h0, "cur_ld");
      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 4'h0, "cur0");
      chk("cursor_off_phase", 4'h0);
      vpulses(8, 0);
      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 4'h0, "cur8");
`ifdef CGA_CURSOR_EN
      cur_exp = 4'h7;
`else
      cur_exp = 4'h0;
`endif
      chk("cursor_on_phase", cur_exp);

      // push frame to 16, then reset mid-cell while video is F
      vpulses(8, 1);
      cyc(1, 1, 8'hFF, 8'h9F, 1, 0, 0, 1, 4'h0, "pre_ld");
      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 4'h0, "pre_reset");
      chk("pre_reset_F", 4'hF);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset", 4'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(1, 1, 8'hFF, 8'h9F, 1, 0, 0, 1, 4'h0, "post_ld");
      cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 4'h0, "post_rst");
      chk("frame_after_reset", 4'h1);

      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 8) == 0,
             8'($urandom), 8'($urandom), $urandom_range(0, 4) != 0,
             1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
             4'($urandom), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
